// File: rtl/song_sequencer_pkg.sv
`timescale 1ns/1ps
// song_sequencer_pkg
// Shared definitions for the song sequencer: FSM state encoding, note codes,
// song ROM geometry and entry field layout, plus two small helpers.
// An entry is packed as {note[6:3], dur[2:0]}. A duration of DUR_END marks
// the end of the song.
package song_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PLAY   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int ROM_DEPTH = 32;
  localparam int ADDR_W    = 5;
  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 3;
  localparam int ENTRY_W   = NOTE_W + DUR_W;
  localparam int ROM_BITS  = ROM_DEPTH * ENTRY_W;

  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd8;

  localparam logic [DUR_W-1:0] DUR_END = 3'd0;

  // Packs one song table entry.
  function automatic logic [ENTRY_W-1:0] mkEntry(input logic [NOTE_W-1:0] note,
                                                 input logic [DUR_W-1:0]  dur);
    return {note, dur};
  endfunction

  // Fixed-priority key arbitration: the lowest-index pressed key wins,
  // REST when nothing is pressed.
  function automatic logic [NOTE_W-1:0] firstKey(input logic [7:0] keys);
    logic [NOTE_W-1:0] result;
    result = NOTE_REST;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i]) result = NOTE_W'(i);
    end
    return result;
  endfunction

  // Short demo tune: E for two ticks, D for one, a rest, then the end marker.
  localparam logic [ROM_BITS-1:0] DEFAULT_SONG = {
    {(ROM_BITS - 4*ENTRY_W){1'b0}},
    mkEntry(NOTE_C4, DUR_END),
    mkEntry(NOTE_REST, 3'd1),
    mkEntry(NOTE_D, 3'd1),
    mkEntry(NOTE_E, 3'd2)
  };

endpackage

// File: rtl/song_rom.sv
`timescale 1ns/1ps
// song_rom
// 32 x 7 song table with a registered read port (one cycle of latency).
// Contents come from the SONG parameter, entry i at bits [i*7 +: 7].
// Ports:
//   clk_i  - system clock
//   addr_i - entry address (0..31)
//   data_o - entry {note, dur}, valid the cycle after addr_i is presented
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter logic [ROM_BITS-1:0] SONG = DEFAULT_SONG
) (
  input  logic               clk_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [ENTRY_W-1:0] data_q;

  // Synchronous read; no reset needed since the data is only consumed in
  // LOAD, which always follows a cycle with a valid address.
  always_ff @(posedge clk_i) begin
    data_q <= SONG[int'(addr_i) * ENTRY_W +: ENTRY_W];
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// song_sequencer
// Plays a tune from the song ROM on a square-wave speaker output, or acts
// as a simple piano (lowest pressed key wins) while idle.
// Ports:
//   CLK          - system clock
//   RESET        - asynchronous active-high reset
//   NOTE_CLK     - square waves per note, bit0=C4 .. bit7=C5
//   QUARTER_BEAT - tempo toggle; each edge is one tick
//   KEYS         - piano keys, active-high, same order as NOTE_CLK
//   PLAY         - start request, acts on its rising edge in IDLE
//   STOP         - abort request, forces IDLE while high
//   SPEAKER      - registered audio output
//   NOTE_IDX     - current note 0..7, 8 for REST
//   PLAYING      - high in LOAD and PLAY
//   SONG_POS     - current ROM address
//   DONE         - one-cycle pulse when the song ends normally
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter logic [ROM_BITS-1:0] SONG = DEFAULT_SONG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        NOTE_CLK,
  input  logic              QUARTER_BEAT,
  input  logic [7:0]        KEYS,
  input  logic              PLAY,
  input  logic              STOP,
  output logic              SPEAKER,
  output logic [NOTE_W-1:0] NOTE_IDX,
  output logic              PLAYING,
  output logic [ADDR_W-1:0] SONG_POS,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(ROM_DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  songPos_q, songPos_d;
  logic [DUR_W-1:0]   remain_q, remain_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               qbPrev_q, playPrev_q, speaker_q;
  logic               tick, playRise;
  logic [ENTRY_W-1:0] romData;
  logic [NOTE_W-1:0]  romNote, noteIdx;
  logic [DUR_W-1:0]   romDur;

  assign tick     = QUARTER_BEAT ^ qbPrev_q;
  assign playRise = PLAY & ~playPrev_q;
  assign romNote  = romData[ENTRY_W-1:DUR_W];
  assign romDur   = romData[DUR_W-1:0];

  // The ROM is addressed with the next position so its registered output
  // already holds the new entry by the time the FSM sits in LOAD.
  song_rom #(.SONG(SONG)) u_rom (
    .clk_i  (CLK),
    .addr_i (songPos_d),
    .data_o (romData)
  );

  // State and datapath registers, plus the tempo/PLAY edge history and
  // the speaker output flop.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      songPos_q  <= '0;
      remain_q   <= '0;
      note_q     <= NOTE_REST;
      qbPrev_q   <= 1'b0;
      playPrev_q <= 1'b0;
      speaker_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      songPos_q  <= songPos_d;
      remain_q   <= remain_d;
      note_q     <= note_d;
      qbPrev_q   <= QUARTER_BEAT;
      playPrev_q <= PLAY;
      speaker_q  <= ~noteIdx[3] & NOTE_CLK[noteIdx[2:0]];
    end
  end

  // Next-state logic. STOP overrides everything, including a PLAY edge or
  // a tick arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    songPos_d = songPos_q;
    remain_d  = remain_q;
    note_d    = note_q;
    if (STOP) begin
      state_d   = S_IDLE;
      songPos_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (playRise) begin
            state_d   = S_LOAD;
            songPos_d = '0;
          end
        end
        S_LOAD: begin
          if (romDur == DUR_END) begin
            state_d = S_FINISH;
          end else begin
            remain_d = romDur;
            note_d   = romNote;
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            remain_d = remain_q - 1'b1;
            if (remain_q == 3'd1) begin
              if (songPos_q == LAST_POS) begin
                state_d = S_FINISH;
              end else begin
                state_d   = S_LOAD;
                songPos_d = songPos_q + 1'b1;
              end
            end
          end
        end
        S_FINISH: begin
          state_d   = S_IDLE;
          songPos_d = '0;
        end
        default: begin
          state_d   = S_IDLE;
          songPos_d = '0;
        end
      endcase
    end
  end

  // Output decode. In IDLE the keys pick the note; during a song only the
  // latched ROM note sounds, and LOAD/FINISH are silent.
  always_comb begin
    PLAYING = 1'b0;
    DONE    = 1'b0;
    noteIdx = NOTE_REST;
    case (state_q)
      S_IDLE:   noteIdx = firstKey(KEYS);
      S_LOAD:   PLAYING = 1'b1;
      S_PLAY: begin
        PLAYING = 1'b1;
        noteIdx = note_q;
      end
      S_FINISH: DONE = 1'b1;
      default:  noteIdx = NOTE_REST;
    endcase
  end

  assign NOTE_IDX = noteIdx;
  assign SPEAKER  = speaker_q;
  assign SONG_POS = songPos_q;

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
// tb_song_sequencer
// Directed bench for song_sequencer. Two instances share clock, reset,
// NOTE_CLK, KEYS and QUARTER_BEAT; each has its own PLAY/STOP so only one
// plays at a time. Instance A holds a short tune, instance B 32 one-tick
// notes with no end marker.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  function automatic logic [ROM_BITS-1:0] buildSongA();
    logic [ROM_BITS-1:0] s;
    s = '0;
    s[0*ENTRY_W +: ENTRY_W] = mkEntry(NOTE_E, 3'd2);
    s[1*ENTRY_W +: ENTRY_W] = mkEntry(NOTE_D, 3'd1);
    s[2*ENTRY_W +: ENTRY_W] = mkEntry(NOTE_REST, 3'd1);
    s[3*ENTRY_W +: ENTRY_W] = mkEntry(NOTE_C4, DUR_END);
    return s;
  endfunction

  function automatic logic [ROM_BITS-1:0] buildSongB();
    logic [ROM_BITS-1:0] s;
    s = '0;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      s[i*ENTRY_W +: ENTRY_W] = mkEntry(NOTE_W'(i % 8), 3'd1);
    end
    return s;
  endfunction

  localparam logic [ROM_BITS-1:0] SONG_A = buildSongA();
  localparam logic [ROM_BITS-1:0] SONG_B = buildSongB();

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] noteClk;
  logic       quarterBeat;
  logic [7:0] keys;
  logic       playA, stopA, playB, stopB;
  logic       speakerA, playingA, doneA;
  logic       speakerB, playingB, doneB;
  logic [3:0] noteIdxA, noteIdxB;
  logic [4:0] songPosA, songPosB;

  int checkCount = 0;
  int failCount  = 0;
  int doneCountA = 0;
  int doneCountB = 0;

  song_sequencer #(.SONG(SONG_A)) dutA (
    .CLK(clk), .RESET(reset), .NOTE_CLK(noteClk), .QUARTER_BEAT(quarterBeat),
    .KEYS(keys), .PLAY(playA), .STOP(stopA), .SPEAKER(speakerA),
    .NOTE_IDX(noteIdxA), .PLAYING(playingA), .SONG_POS(songPosA), .DONE(doneA)
  );

  song_sequencer #(.SONG(SONG_B)) dutB (
    .CLK(clk), .RESET(reset), .NOTE_CLK(noteClk), .QUARTER_BEAT(quarterBeat),
    .KEYS(keys), .PLAY(playB), .STOP(stopB), .SPEAKER(speakerB),
    .NOTE_IDX(noteIdxB), .PLAYING(playingB), .SONG_POS(songPosB), .DONE(doneB)
  );

  always #5 clk = ~clk;

  // Counts DONE pulses so extra or missing pulses show up in later checks.
  always @(negedge clk) begin
    if (doneA === 1'b1) doneCountA++;
    if (doneB === 1'b1) doneCountB++;
  end

  // Stops a hung run with a failure line instead of spinning forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of control inputs (optionally toggling the tempo line)
  // and returns at the next falling edge, after the DUT has clocked once.
  task automatic applyStimulus(input logic pA, input logic sA, input logic pB,
                               input logic sB, input logic tickIt);
    playA = pA;
    stopA = sA;
    playB = pB;
    stopB = sB;
    if (tickIt) quarterBeat = ~quarterBeat;
    @(negedge clk);
  endtask

  // Plays tune A with ticks every 8 clocks; hold keeps PLAY high throughout.
  task automatic playSongA(input logic hold);
    int   expNote[4] = '{2, 2, 1, 8};
    int   expPos[4]  = '{0, 0, 1, 2};
    int   expSpk[4]  = '{1, 1, 0, 0};
    int   doneBefore;
    doneBefore = doneCountA;
    noteClk = 8'b1111_1101;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("A load playing", playingA, 1);
    checkOutput("A load note", noteIdxA, 8);
    applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (7) applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("A note", noteIdxA, expNote[k]);
      checkOutput("A pos", songPosA, expPos[k]);
      checkOutput("A speaker", speakerA, expSpk[k]);
      applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("A end load pos", songPosA, 3);
    checkOutput("A end load note", noteIdxA, 8);
    applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("A finish done", doneA, 1);
    checkOutput("A finish playing", playingA, 0);
    applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("A idle done", doneA, 0);
    checkOutput("A idle playing", playingA, 0);
    checkOutput("A idle pos", songPosA, 0);
    repeat (3) applyStimulus(hold, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("A no restart", playingA, 0);
    checkOutput("A done count", doneCountA, doneBefore + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    noteClk = 8'h00;
    quarterBeat = 1'b0;
    keys = 8'h00;
    playA = 1'b0; stopA = 1'b0; playB = 1'b0; stopB = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset A speaker", speakerA, 0);
    checkOutput("reset A note", noteIdxA, 8);
    checkOutput("reset A playing", playingA, 0);
    checkOutput("reset A pos", songPosA, 0);
    checkOutput("reset A done", doneA, 0);
    checkOutput("reset B speaker", speakerB, 0);
    checkOutput("reset B note", noteIdxB, 8);
    checkOutput("reset B playing", playingB, 0);
    checkOutput("reset B pos", songPosB, 0);
    checkOutput("reset B done", doneB, 0);
    reset = 1'b0;
    @(negedge clk);

    // Piano mode: arbitration and one-cycle speaker delay.
    keys = 8'b0010_0100;
    noteClk = 8'b0000_0100;
    #1;
    checkOutput("keys note", noteIdxA, 2);
    checkOutput("keys speaker before edge", speakerA, 0);
    @(negedge clk);
    checkOutput("keys speaker high", speakerA, 1);
    noteClk = 8'b1111_1011;
    #1;
    checkOutput("keys speaker held", speakerA, 1);
    @(negedge clk);
    checkOutput("keys speaker low", speakerA, 0);
    keys = 8'b1000_0000;
    noteClk = 8'h80;
    #1;
    checkOutput("keys note C5", noteIdxA, 7);
    @(negedge clk);
    checkOutput("keys speaker C5", speakerA, 1);
    keys = 8'h00;
    noteClk = 8'hFF;
    #1;
    checkOutput("no keys note", noteIdxA, 8);
    @(negedge clk);
    checkOutput("no keys speaker", speakerA, 0);

    playSongA(1'b0);
    playSongA(1'b1);

    // STOP together with a tick while playing entry 1.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stop pre pos", songPosA, 1);
    checkOutput("stop pre note", noteIdxA, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("stop playing", playingA, 0);
    checkOutput("stop pos", songPosA, 0);
    checkOutput("stop done", doneA, 0);
    checkOutput("stop note", noteIdxA, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stop done count", doneCountA, 2);

    // Reset in the middle of a note.
    noteClk = 8'h04;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre reset speaker", speakerA, 1);
    checkOutput("pre reset playing", playingA, 1);
    reset = 1'b1;
    #1;
    checkOutput("async reset speaker", speakerA, 0);
    checkOutput("async reset note", noteIdxA, 8);
    checkOutput("async reset playing", playingA, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("post reset idle", playingA, 0);
    end
    checkOutput("reset done count", doneCountA, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post reset start", playingA, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Instance B: PLAY edge ignored mid-song at position 3.
    noteClk = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("B pos 3", songPosB, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("B replay pos", songPosB, 3);
    checkOutput("B replay note", noteIdxB, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("B advance pos", songPosB, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("B advance note", noteIdxB, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("B stop pos", songPosB, 0);
    checkOutput("B stop done", doneB, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Instance B: full 32-entry song without end marker, no wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checkOutput("B full pos", songPosB, i);
      checkOutput("B full note", noteIdxB, i % 8);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i < 31) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("B finish done", doneB, 1);
    checkOutput("B finish playing", playingB, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("B idle pos", songPosB, 0);
    checkOutput("B idle done", doneB, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("B done count", doneCountB, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
